// File: rtl/button_conditioner.sv
// Synchronises and debounces four raw push-buttons into clean levels and press pulses,
// and derives a single-cycle refresh_tick once per VGA frame from the pixel counters.
module button_conditioner #(
    parameter int DB_CYCLES = 1_000_000,
    parameter int Y_TICK    = 481,
    parameter int X_TICK    = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btnU_raw,
    input  logic       btnL_raw,
    input  logic       btnD_raw,
    input  logic       btnR_raw,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       btnU,
    output logic       btnL,
    output logic       btnD,
    output logic       btnR,
    output logic [3:0] btn_press,
    output logic       refresh_tick
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        LOW    = 2'd0,
        ARM_HI = 2'd1,
        HIGH   = 2'd2,
        ARM_LO = 2'd3
    } db_state_t;

    logic [3:0] btn_raw;
    logic [3:0] sync_p0;
    logic [3:0] sync_p1;
    logic [3:0] level_vec;
    logic [3:0] press_vec;

    // Channel order {U,L,D,R}, so bit 3 is U and bit 0 is R throughout.
    assign btn_raw = {btnU_raw, btnL_raw, btnD_raw, btnR_raw};

    // Stage p0 -> p1: two-flop synchroniser, the FSMs only ever look at p1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_ch
        db_state_t        state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             level_q, level_d;
        logic             press_q, press_d;
        logic             s2;

        assign s2 = sync_p1[i];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                state_q <= LOW;
                cnt_q   <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                level_q <= level_d;
                press_q <= press_d;
            end
        end

        // Counter is cleared on every state change, so it never needs to wrap.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            level_d = level_q;
            press_d = 1'b0;
            case (state_q)
                LOW: begin
                    if (s2) begin
                        state_d = ARM_HI;
                        cnt_d   = '0;
                    end
                end
                ARM_HI: begin
                    if (!s2) begin
                        state_d = LOW;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                        level_d = 1'b1;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (!s2) begin
                        state_d = ARM_LO;
                        cnt_d   = '0;
                    end
                end
                ARM_LO: begin
                    if (s2) begin
                        state_d = HIGH;
                        cnt_d   = '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = LOW;
                        cnt_d   = '0;
                        level_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end
            endcase
        end

        assign level_vec[i] = level_q;
        assign press_vec[i] = press_q;
    end

    assign btnU      = level_vec[3];
    assign btnL      = level_vec[2];
    assign btnD      = level_vec[1];
    assign btnR      = level_vec[0];
    assign btn_press = press_vec;

    logic match_p0;
    logic match_p1;
    logic tick_q;

    assign match_p0 = (x == 10'(X_TICK)) && (y == 10'(Y_TICK));

    // Stage p0 -> p1: rising-edge detect, x holds X_TICK for several clocks per pixel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            match_p1 <= 1'b0;
            tick_q   <= 1'b0;
        end else begin
            match_p1 <= match_p0;
            tick_q   <= match_p0 & ~match_p1;
        end
    end

    assign refresh_tick = tick_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with DB_CYCLES=4: expected outputs are queued
// as each cycle's stimulus is applied and compared one clock edge later.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btnU_raw = 1'b0, btnL_raw = 1'b0, btnD_raw = 1'b0, btnR_raw = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic       btnU, btnL, btnD, btnR;
    logic [3:0] btn_press;
    logic       refresh_tick;

    typedef struct packed {
        logic [3:0] lvl;
        logic [3:0] press;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    exp_t e, w;
    int   n_cmp = 0;
    int   n_bad = 0;

    button_conditioner #(.DB_CYCLES(4), .Y_TICK(481), .X_TICK(0)) dut (
        .clk(clk), .reset(reset),
        .btnU_raw(btnU_raw), .btnL_raw(btnL_raw), .btnD_raw(btnD_raw), .btnR_raw(btnR_raw),
        .x(x), .y(y),
        .btnU(btnU), .btnL(btnL), .btnD(btnD), .btnR(btnR),
        .btn_press(btn_press), .refresh_tick(refresh_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    // Stimulus only: puts the DUT in a known idle state, ending on a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        {btnU_raw, btnL_raw, btnD_raw, btnR_raw} = 4'b0000;
        x = '0; y = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        {btnU_raw, btnL_raw, btnD_raw, btnR_raw} = 4'b1111;
        for (int t = 0; t < 3; t++) begin
            e.lvl = 4'h0; e.press = 4'h0; e.tick = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1;
            w = exp_q.pop_front();
            n_cmp++;
            if ({btnU, btnL, btnD, btnR} !== w.lvl || btn_press !== w.press || refresh_tick !== w.tick) begin
                n_bad++;
                $display("FAIL reset_hold t=%0d got lvl=%b press=%b tick=%b want lvl=%b press=%b tick=%b",
                         t, {btnU, btnL, btnD, btnR}, btn_press, refresh_tick, w.lvl, w.press, w.tick);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        for (int t = 1; t <= 9; t++) begin
            e.lvl = (t >= 7) ? 4'hF : 4'h0; e.press = (t == 7) ? 4'hF : 4'h0; e.tick = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1;
            w = exp_q.pop_front();
            n_cmp++;
            if ({btnU, btnL, btnD, btnR} !== w.lvl || btn_press !== w.press || refresh_tick !== w.tick) begin
                n_bad++;
                $display("FAIL reset_release t=%0d got lvl=%b press=%b tick=%b want lvl=%b press=%b tick=%b",
                         t, {btnU, btnL, btnD, btnR}, btn_press, refresh_tick, w.lvl, w.press, w.tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int t = 1; t <= 15; t++) begin
            btnL_raw = (t <= 3);
            e.lvl = 4'h0; e.press = 4'h0; e.tick = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1;
            w = exp_q.pop_front();
            n_cmp++;
            if ({btnU, btnL, btnD, btnR} !== w.lvl || btn_press !== w.press || refresh_tick !== w.tick) begin
                n_bad++;
                $display("FAIL glitch t=%0d got lvl=%b press=%b tick=%b want lvl=%b press=%b tick=%b",
                         t, {btnU, btnL, btnD, btnR}, btn_press, refresh_tick, w.lvl, w.press, w.tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_release();
        do_reset();
        for (int t = 1; t <= 30; t++) begin
            btnR_raw = (t < 21) && !(t == 11 || t == 12);
            e.lvl = (t >= 7 && t < 27) ? 4'b0001 : 4'b0000;
            e.press = (t == 7) ? 4'b0001 : 4'b0000;
            e.tick = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1;
            w = exp_q.pop_front();
            n_cmp++;
            if ({btnU, btnL, btnD, btnR} !== w.lvl || btn_press !== w.press || refresh_tick !== w.tick) begin
                n_bad++;
                $display("FAIL release t=%0d got lvl=%b press=%b tick=%b want lvl=%b press=%b tick=%b",
                         t, {btnU, btnL, btnD, btnR}, btn_press, refresh_tick, w.lvl, w.press, w.tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_independent();
        do_reset();
        for (int t = 1; t <= 12; t++) begin
            btnU_raw = 1'b1;
            btnD_raw = (t >= 3);
            e.lvl = {(t >= 7), 1'b0, (t >= 9), 1'b0};
            e.press = {(t == 7), 1'b0, (t == 9), 1'b0};
            e.tick = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1;
            w = exp_q.pop_front();
            n_cmp++;
            if ({btnU, btnL, btnD, btnR} !== w.lvl || btn_press !== w.press || refresh_tick !== w.tick) begin
                n_bad++;
                $display("FAIL independent t=%0d got lvl=%b press=%b tick=%b want lvl=%b press=%b tick=%b",
                         t, {btnU, btnL, btnD, btnR}, btn_press, refresh_tick, w.lvl, w.press, w.tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int t = 1; t <= 7; t++) begin
            // Cycles 1..5 debounce into ARM_HI with cnt=2, then reset is held for two edges.
            if (t == 6) reset = 1'b1;
            btnU_raw = 1'b1;
            e.lvl = 4'h0; e.press = 4'h0; e.tick = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1;
            w = exp_q.pop_front();
            n_cmp++;
            if ({btnU, btnL, btnD, btnR} !== w.lvl || btn_press !== w.press || refresh_tick !== w.tick) begin
                n_bad++;
                $display("FAIL reset_mid_abort t=%0d got lvl=%b press=%b tick=%b want lvl=%b press=%b tick=%b",
                         t, {btnU, btnL, btnD, btnR}, btn_press, refresh_tick, w.lvl, w.press, w.tick);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        for (int t = 1; t <= 9; t++) begin
            e.lvl = (t >= 7) ? 4'b1000 : 4'b0000; e.press = (t == 7) ? 4'b1000 : 4'b0000; e.tick = 1'b0;
            exp_q.push_back(e);
            @(posedge clk); #1;
            w = exp_q.pop_front();
            n_cmp++;
            if ({btnU, btnL, btnD, btnR} !== w.lvl || btn_press !== w.press || refresh_tick !== w.tick) begin
                n_bad++;
                $display("FAIL reset_mid_relatch t=%0d got lvl=%b press=%b tick=%b want lvl=%b press=%b tick=%b",
                         t, {btnU, btnL, btnD, btnR}, btn_press, refresh_tick, w.lvl, w.press, w.tick);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_frame();
        int ticks;
        do_reset();
        // Reset released while the match position is already present.
        reset = 1'b1; x = 10'd0; y = 10'd481;
        @(negedge clk);
        reset = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            e.lvl = 4'h0; e.press = 4'h0; e.tick = (t == 1);
            exp_q.push_back(e);
            @(posedge clk); #1;
            w = exp_q.pop_front();
            n_cmp++;
            if (refresh_tick !== w.tick) begin
                n_bad++;
                $display("FAIL tick_after_reset t=%0d got tick=%b want tick=%b", t, refresh_tick, w.tick);
            end
            @(negedge clk);
        end
        x = 10'd0; y = 10'd0;
        @(negedge clk);

        // Full-width sweep of the rows around the tick row.
        ticks = 0;
        for (int yy = 479; yy <= 483; yy++) begin
            for (int xx = 0; xx < 800; xx++) begin
                for (int k = 0; k < 4; k++) begin
                    x = 10'(xx); y = 10'(yy);
                    e.lvl = 4'h0; e.press = 4'h0; e.tick = (xx == 0 && yy == 481 && k == 0);
                    exp_q.push_back(e);
                    @(posedge clk); #1;
                    w = exp_q.pop_front();
                    n_cmp++;
                    if (refresh_tick !== w.tick) begin
                        n_bad++;
                        $display("FAIL tick_rows x=%0d y=%0d k=%0d got tick=%b want tick=%b",
                                 xx, yy, k, refresh_tick, w.tick);
                    end
                    if (refresh_tick === 1'b1) ticks++;
                    @(negedge clk);
                end
            end
        end
        n_cmp++;
        if (ticks !== 1) begin
            n_bad++;
            $display("FAIL tick_rows_count got %0d want 1", ticks);
        end

        // Every row of the frame, across the line wrap 798,799,0,1.
        ticks = 0;
        for (int yy = 0; yy < 525; yy++) begin
            for (int j = 0; j < 4; j++) begin
                for (int k = 0; k < 4; k++) begin
                    x = 10'((j + 798) % 800); y = 10'(yy);
                    e.lvl = 4'h0; e.press = 4'h0; e.tick = (j == 2 && yy == 481 && k == 0);
                    exp_q.push_back(e);
                    @(posedge clk); #1;
                    w = exp_q.pop_front();
                    n_cmp++;
                    if (refresh_tick !== w.tick) begin
                        n_bad++;
                        $display("FAIL tick_cols x=%0d y=%0d k=%0d got tick=%b want tick=%b",
                                 (j + 798) % 800, yy, k, refresh_tick, w.tick);
                    end
                    if (refresh_tick === 1'b1) ticks++;
                    @(negedge clk);
                end
            end
        end
        n_cmp++;
        if (ticks !== 1) begin
            n_bad++;
            $display("FAIL tick_frame_count got %0d want 1", ticks);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_glitch();
        test_release();
        test_independent();
        test_reset_mid();
        test_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
